// File: rtl/config_seq_pkg.sv
// Shared definitions for the configuration frame sequencer.
//  - CFG_SYNC and header field positions of the 32-bit header word
//  - FSM state encoding
//  - counter width helper used to size row/frame/column/index registers
package config_seq_pkg;

    localparam logic [7:0] CFG_SYNC      = 8'hFA;
    localparam int         HDR_FIELD_W   = 8;
    localparam int         HDR_SYNC_LSB  = 24;
    localparam int         HDR_COL_LSB   = 16;
    localparam int         HDR_START_LSB = 8;
    localparam int         HDR_COUNT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2
    } seq_state_t;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/config_strobe_decoder.sv
// Registered one-hot decoder for the column/frame strobe plane.
// Ports:
//  clk     in   config clock
//  resetn  in   synchronous active-low reset
//  col     in   target column
//  frame   in   target frame within the column
//  en      in   issue a strobe in the next cycle
//  strobe  out  registered one-hot, bit col*MAX_FRAMES+frame; all-zero when en was low
module config_strobe_decoder
    import config_seq_pkg::*;
#(
    parameter int NUM_COLUMNS = 8,
    parameter int MAX_FRAMES  = 20
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [cnt_width(NUM_COLUMNS)-1:0]       col,
    input  logic [cnt_width(MAX_FRAMES)-1:0]        frame,
    input  logic                                    en,
    output logic [NUM_COLUMNS*MAX_FRAMES-1:0]       strobe
);

    localparam int TOTAL = NUM_COLUMNS * MAX_FRAMES;
    localparam int IDX_W = cnt_width(TOTAL);

    logic [IDX_W-1:0] idx_s;
    logic [TOTAL-1:0] onehot_s;
    logic [TOTAL-1:0] strobe_r;

    // Flatten (col, frame) to a strobe index and expand it to one-hot.
    always_comb begin
        onehot_s = '0;
        idx_s    = IDX_W'(col) * IDX_W'(MAX_FRAMES) + IDX_W'(frame);
        for (int i = 0; i < TOTAL; i++) begin
            if (en && (idx_s == IDX_W'(i))) begin
                onehot_s[i] = 1'b1;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
    end

    // Register the strobe so it is a clean single-cycle pulse with no input path.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            strobe_r <= '0;
        end else begin
            strobe_r <= onehot_s;
        end
    end

    assign strobe = strobe_r;

endmodule

// File: rtl/config_frame_sequencer.sv
// Streams header-framed configuration words into the frame-based config plane.
// A valid header selects a column, a start frame and a frame count; each frame
// is assembled from NUM_ROWS words and then strobed into its column/frame latch.
// Ports:
//  CLK             in   config clock
//  resetn          in   synchronous active-low reset
//  s_data/s_valid  in   word stream (header or frame data)
//  s_ready         out  word accepted when s_valid && s_ready
//  frame_data_o    out  assembled frame, row r at [r*FRAME_BITS +: FRAME_BITS]
//  frame_strobe_o  out  one-hot strobe, bit col*MAX_FRAMES+frame
//  busy_o          out  high while a burst is in progress
//  done_o          out  one-cycle pulse with the final strobe of a burst
//  err_o           out  sticky header error, cleared by a valid header
module config_frame_sequencer
    import config_seq_pkg::*;
#(
    parameter int FRAME_BITS  = 32,
    parameter int NUM_ROWS    = 4,
    parameter int NUM_COLUMNS = 8,
    parameter int MAX_FRAMES  = 20
) (
    input  logic                              CLK,
    input  logic                              resetn,
    input  logic [FRAME_BITS-1:0]             s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [NUM_ROWS*FRAME_BITS-1:0]    frame_data_o,
    output logic [NUM_COLUMNS*MAX_FRAMES-1:0] frame_strobe_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o
);

    localparam int ROW_W   = cnt_width(NUM_ROWS);
    localparam int COL_W   = cnt_width(NUM_COLUMNS);
    localparam int FRAME_W = cnt_width(MAX_FRAMES);
    localparam int REM_W   = cnt_width(MAX_FRAMES + 1);

    seq_state_t                    state_r;
    logic [ROW_W-1:0]              row_r;
    logic [COL_W-1:0]              col_r;
    logic [FRAME_W-1:0]            frame_r;
    logic [REM_W-1:0]              remain_r;
    logic [NUM_ROWS*FRAME_BITS-1:0] frame_data_r;
    logic                          s_ready_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          err_r;

    logic [HDR_FIELD_W-1:0]        hdr_sync_s;
    logic [HDR_FIELD_W-1:0]        hdr_col_s;
    logic [HDR_FIELD_W-1:0]        hdr_start_s;
    logic [HDR_FIELD_W-1:0]        hdr_count_s;
    logic [HDR_FIELD_W:0]          hdr_sum_s;
    logic                          hdr_ok_s;
    logic                          accept_s;
    logic                          last_row_s;
    logic                          strobe_en_s;

    // Header field extraction and validity; the 9-bit sum cannot wrap.
    always_comb begin
        hdr_sync_s  = s_data[HDR_SYNC_LSB  +: HDR_FIELD_W];
        hdr_col_s   = s_data[HDR_COL_LSB   +: HDR_FIELD_W];
        hdr_start_s = s_data[HDR_START_LSB +: HDR_FIELD_W];
        hdr_count_s = s_data[HDR_COUNT_LSB +: HDR_FIELD_W];
        hdr_sum_s   = {1'b0, hdr_start_s} + {1'b0, hdr_count_s};
        if ((hdr_sync_s == CFG_SYNC) &&
            (hdr_col_s < HDR_FIELD_W'(NUM_COLUMNS)) &&
            (hdr_count_s != {HDR_FIELD_W{1'b0}}) &&
            (hdr_sum_s <= (HDR_FIELD_W + 1)'(MAX_FRAMES))) begin
            hdr_ok_s = 1'b1;
        end else begin
            hdr_ok_s = 1'b0;
        end
    end

    // Handshake and strobe request: the strobe is requested on the edge that
    // accepts the last row, so the registered decoder fires in the STROBE cycle.
    always_comb begin
        accept_s   = s_valid && s_ready_r;
        last_row_s = (row_r == ROW_W'(NUM_ROWS - 1));
        if ((state_r == LOAD) && accept_s && last_row_s) begin
            strobe_en_s = 1'b1;
        end else begin
            strobe_en_s = 1'b0;
        end
    end

    // Sequencer FSM with counters, frame register and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_r      <= IDLE;
            row_r        <= '0;
            col_r        <= '0;
            frame_r      <= '0;
            remain_r     <= '0;
            frame_data_r <= '0;
            s_ready_r    <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (hdr_ok_s) begin
                            col_r    <= COL_W'(hdr_col_s);
                            frame_r  <= FRAME_W'(hdr_start_s);
                            remain_r <= REM_W'(hdr_count_s);
                            row_r    <= '0;
                            err_r    <= 1'b0;
                            busy_r   <= 1'b1;
                            state_r  <= LOAD;
                        end else begin
                            err_r    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        for (int r = 0; r < NUM_ROWS; r++) begin
                            if (row_r == ROW_W'(r)) begin
                                frame_data_r[r*FRAME_BITS +: FRAME_BITS] <= s_data;
                            end
                        end
                        if (last_row_s) begin
                            s_ready_r <= 1'b0;
                            done_r    <= (remain_r == REM_W'(1));
                            state_r   <= STROBE;
                        end else begin
                            row_r     <= row_r + ROW_W'(1);
                        end
                    end
                end
                STROBE: begin
                    s_ready_r <= 1'b1;
                    row_r     <= '0;
                    if (remain_r > REM_W'(1)) begin
                        frame_r  <= frame_r + FRAME_W'(1);
                        remain_r <= remain_r - REM_W'(1);
                        state_r  <= LOAD;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    s_ready_r <= 1'b1;
                    busy_r    <= 1'b0;
                    row_r     <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    config_strobe_decoder #(
        .NUM_COLUMNS (NUM_COLUMNS),
        .MAX_FRAMES  (MAX_FRAMES)
    ) u_strobe_decoder (
        .clk    (CLK),
        .resetn (resetn),
        .col    (col_r),
        .frame  (frame_r),
        .en     (strobe_en_s),
        .strobe (frame_strobe_o)
    );

    assign s_ready      = s_ready_r;
    assign frame_data_o = frame_data_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Directed testbench for config_frame_sequencer (default parameters).
module tb_config_frame_sequencer;

    logic         clk;
    logic         resetn;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] frame_data_o;
    logic [159:0] frame_strobe_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    int total = 0;
    int bad   = 0;
    int strobe_cycles = 0;
    int done_pulses   = 0;
    int gaps [12] = '{1, 0, 2, 1, 0, 1, 2, 0, 1, 1, 0, 2};

    logic [31:0] prev_data;
    logic        prev_stall = 1'b0;

    config_frame_sequencer dut (
        .CLK            (clk),
        .resetn         (resetn),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .frame_data_o   (frame_data_o),
        .frame_strobe_o (frame_strobe_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] bit_at(input int i);
        logic [159:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Present one word and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("send_timeout", 160'(n), 160'(0));
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Continuous protocol checks sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            total++;
            assert ($onehot0(frame_strobe_o)) else begin
                bad++;
                $error("FAIL strobe_onehot observed=%0h expected=onehot0", frame_strobe_o);
            end
            total++;
            assert (!((frame_strobe_o != '0) && s_ready)) else begin
                bad++;
                $error("FAIL strobe_ready observed=%0b expected=0", s_ready);
            end
            if (prev_stall && s_valid) begin
                total++;
                assert (s_data === prev_data) else begin
                    bad++;
                    $error("FAIL data_stable observed=%0h expected=%0h", s_data, prev_data);
                end
            end
            if (frame_strobe_o != '0) strobe_cycles++;
            if (done_o) done_pulses++;
        end
        prev_stall = s_valid && !s_ready;
        prev_data  = s_data;
    end

    initial begin
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst_data",   160'(frame_data_o), 160'(0));
        chk("rst_strobe", frame_strobe_o, 160'(0));
        chk("rst_busy",   160'(busy_o), 160'(0));
        chk("rst_done",   160'(done_o), 160'(0));
        chk("rst_err",    160'(err_o), 160'(0));
        chk("rst_ready",  160'(s_ready), 160'(1));

        // Test 1: two frames to column 3 starting at frame 5.
        send(32'hFA03_0502);
        chk("t1_busy", 160'(busy_o), 160'(1));
        send(32'h11); send(32'h12); send(32'h13);
        chk("t1_no_strobe", frame_strobe_o, 160'(0));
        send(32'h14);
        chk("t1_strobe65", frame_strobe_o, bit_at(65));
        chk("t1_ready0",   160'(s_ready), 160'(0));
        chk("t1_data0",    160'(frame_data_o), 160'(128'h00000014_00000013_00000012_00000011));
        chk("t1_done0",    160'(done_o), 160'(0));
        send(32'h15); send(32'h16); send(32'h17); send(32'h18);
        chk("t1_strobe66", frame_strobe_o, bit_at(66));
        chk("t1_done1",    160'(done_o), 160'(1));
        chk("t1_data1",    160'(frame_data_o), 160'(128'h00000018_00000017_00000016_00000015));
        step();
        chk("t1_idle_busy",   160'(busy_o), 160'(0));
        chk("t1_idle_ready",  160'(s_ready), 160'(1));
        chk("t1_idle_strobe", frame_strobe_o, 160'(0));
        chk("t1_idle_done",   160'(done_o), 160'(0));

        // Test 2: rejected headers, then a legal start+N==MAX header.
        send(32'hFB03_0502);
        chk("t2_sync_err",  160'(err_o), 160'(1));
        chk("t2_sync_busy", 160'(busy_o), 160'(0));
        send(32'hFA08_0001);
        chk("t2_col_err",   160'(err_o), 160'(1));
        chk("t2_col_busy",  160'(busy_o), 160'(0));
        send(32'hFA03_0500);
        chk("t2_n0_err",    160'(err_o), 160'(1));
        chk("t2_n0_busy",   160'(busy_o), 160'(0));
        send(32'hFA00_1302);
        chk("t2_ovf_err",   160'(err_o), 160'(1));
        chk("t2_ovf_busy",  160'(busy_o), 160'(0));
        chk("t2_no_strobe", 160'(strobe_cycles), 160'(2));
        send(32'hFA00_1301);
        chk("t2_err_clr",   160'(err_o), 160'(0));
        chk("t2_busy",      160'(busy_o), 160'(1));
        send(32'h21); send(32'h22); send(32'h23); send(32'h24);
        chk("t2_strobe19",  frame_strobe_o, bit_at(19));
        chk("t2_done",      160'(done_o), 160'(1));
        chk("t2_data",      160'(frame_data_o), 160'(128'h00000024_00000023_00000022_00000021));
        step();

        // Test 3: three frames to column 7 with idle gaps between words.
        send(32'hFA07_0003);
        for (int w = 0; w < 12; w++) begin
            repeat (gaps[w]) step();
            send(32'h31 + 32'(w));
            if (w == 3) begin
                chk("t3_strobe140", frame_strobe_o, bit_at(140));
                chk("t3_data0", 160'(frame_data_o), 160'(128'h00000034_00000033_00000032_00000031));
            end else if (w == 7) begin
                chk("t3_strobe141", frame_strobe_o, bit_at(141));
                chk("t3_data1", 160'(frame_data_o), 160'(128'h00000038_00000037_00000036_00000035));
            end else if (w == 11) begin
                chk("t3_strobe142", frame_strobe_o, bit_at(142));
                chk("t3_data2", 160'(frame_data_o), 160'(128'h0000003C_0000003B_0000003A_00000039));
                chk("t3_done",  160'(done_o), 160'(1));
            end
        end
        step();
        chk("t3_strobe_cycles", 160'(strobe_cycles), 160'(6));

        // Test 4: next header held valid through the final strobe cycle.
        send(32'hFA02_0101);
        send(32'h41); send(32'h42); send(32'h43); send(32'h44);
        s_data  = 32'hFA01_0001;
        s_valid = 1'b1;
        chk("t4_strobe41", frame_strobe_o, bit_at(41));
        chk("t4_ready0",   160'(s_ready), 160'(0));
        chk("t4_done",     160'(done_o), 160'(1));
        step();
        chk("t4_not_taken", 160'(busy_o), 160'(0));
        chk("t4_ready1",    160'(s_ready), 160'(1));
        step();
        s_valid = 1'b0;
        chk("t4_taken",     160'(busy_o), 160'(1));
        chk("t4_done_once", 160'(done_pulses), 160'(4));
        send(32'h45); send(32'h46); send(32'h47); send(32'h48);
        chk("t4_strobe20",  frame_strobe_o, bit_at(20));
        step();

        // Test 5: reset in the middle of a frame.
        send(32'hFA04_0A04);
        send(32'h51); send(32'h52);
        resetn = 1'b0;
        step();
        chk("t5_data",   160'(frame_data_o), 160'(0));
        chk("t5_strobe", frame_strobe_o, 160'(0));
        chk("t5_busy",   160'(busy_o), 160'(0));
        chk("t5_done",   160'(done_o), 160'(0));
        chk("t5_err",    160'(err_o), 160'(0));
        resetn = 1'b1;
        repeat (3) step();
        chk("t5_no_strobe", 160'(strobe_cycles), 160'(8));
        send(32'hFA05_0001);
        send(32'h61); send(32'h62); send(32'h63); send(32'h64);
        chk("t5_strobe100", frame_strobe_o, bit_at(100));
        chk("t5_data_new",  160'(frame_data_o), 160'(128'h00000064_00000063_00000062_00000061));
        step();
        chk("t5_final_busy",  160'(busy_o), 160'(0));
        chk("total_strobes",  160'(strobe_cycles), 160'(9));
        chk("total_done",     160'(done_pulses), 160'(6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
